// File: rtl/regfile_sb.sv
// Register file with one write port, two combinational read ports, optional
// write-through bypass, optional hardwired-zero register 0 and a busy scoreboard.
module regfile_sb #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic             regWrite,
    input  logic [AW-1:0]    writeReg,
    input  logic [WIDTH-1:0] writeData,
    input  logic             reserveEn,
    input  logic [AW-1:0]    reserveReg,
    input  logic [AW-1:0]    readReg1,
    input  logic [AW-1:0]    readReg2,
    output logic [WIDTH-1:0] readData1,
    output logic [WIDTH-1:0] readData2,
    output logic             busy1,
    output logic             busy2,
    output logic [AW:0]      busyCount
);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic [AW:0]      busyCount_q;
    logic [AW:0]      busyCount_d;

    logic writeValid;
    logic reserveValid;
    logic zero1;
    logic zero2;
    logic bypass1;
    logic bypass2;

    // Register 0 swallows writes and reserves when it is hardwired to zero.
    assign writeValid   = regWrite  && !(ZERO_REG && (writeReg   == '0));
    assign reserveValid = reserveEn && !(ZERO_REG && (reserveReg == '0));

    // Release first, then reserve, so a same-register reserve wins.
    always_comb begin
        busy_d = busy_q;
        if (writeValid) begin
            busy_d[writeReg] = 1'b0;
        end
        if (reserveValid) begin
            busy_d[reserveReg] = 1'b1;
        end
    end

    always_comb begin
        busyCount_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busyCount_d = busyCount_d + {{AW{1'b0}}, busy_d[i]};
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            busy_q      <= '0;
            busyCount_q <= '0;
        end else begin
            busy_q      <= busy_d;
            busyCount_q <= busyCount_d;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (writeValid) begin
            regs_q[writeReg] <= writeData;
        end
    end

    // The bypass is gated by reset so a write strobe held during reset stays invisible.
    assign zero1   = ZERO_REG && (readReg1 == '0);
    assign zero2   = ZERO_REG && (readReg2 == '0);
    assign bypass1 = BYPASS && resetN && regWrite && (writeReg == readReg1);
    assign bypass2 = BYPASS && resetN && regWrite && (writeReg == readReg2);

    always_comb begin
        readData1 = regs_q[readReg1];
        busy1     = busy_q[readReg1];
        if (zero1) begin
            readData1 = '0;
            busy1     = 1'b0;
        end else if (bypass1) begin
            readData1 = writeData;
            busy1     = 1'b0;
        end
    end

    always_comb begin
        readData2 = regs_q[readReg2];
        busy2     = busy_q[readReg2];
        if (zero2) begin
            readData2 = '0;
            busy2     = 1'b0;
        end else if (bypass2) begin
            readData2 = writeData;
            busy2     = 1'b0;
        end
    end

    assign busyCount = busyCount_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a default build (bypass, zero register) and a small
// 16x8 build without bypass or zero register, both tracked by array models.
module tb_regfile_sb;

    logic clock  = 1'b0;
    logic resetN = 1'b1;

    logic        wrA, resA;
    logic [4:0]  wRegA, resRegA, rd1A, rd2A;
    logic [31:0] wDataA, rData1A, rData2A;
    logic        busy1A, busy2A;
    logic [5:0]  cntA;

    logic        wrB, resB;
    logic [2:0]  wRegB, resRegB, rd1B, rd2B;
    logic [15:0] wDataB, rData1B, rData2B;
    logic        busy1B, busy2B;
    logic [3:0]  cntB;

    int total = 0;
    int bad   = 0;
    bit checkEn = 1'b0;

    logic [31:0] mRegA [32];
    bit          mBusyA [32];
    logic [15:0] mRegB [8];
    bit          mBusyB [8];

    regfile_sb #(.WIDTH(32), .DEPTH(32), .BYPASS(1'b1), .ZERO_REG(1'b1)) dutA (
        .clock(clock), .resetN(resetN),
        .regWrite(wrA), .writeReg(wRegA), .writeData(wDataA),
        .reserveEn(resA), .reserveReg(resRegA),
        .readReg1(rd1A), .readReg2(rd2A),
        .readData1(rData1A), .readData2(rData2A),
        .busy1(busy1A), .busy2(busy2A), .busyCount(cntA)
    );

    regfile_sb #(.WIDTH(16), .DEPTH(8), .BYPASS(1'b0), .ZERO_REG(1'b0)) dutB (
        .clock(clock), .resetN(resetN),
        .regWrite(wrB), .writeReg(wRegB), .writeData(wDataB),
        .reserveEn(resB), .reserveReg(resRegB),
        .readReg1(rd1B), .readReg2(rd2B),
        .readData1(rData1B), .readData2(rData2B),
        .busy1(busy1B), .busy2(busy2B), .busyCount(cntB)
    );

    always #5 clock = ~clock;

    // Reference state: a write stores data and frees the register, a reserve
    // claims it afterwards so it wins on a collision.
    always @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < 32; i++) begin
                mRegA[i]  <= '0;
                mBusyA[i] <= 1'b0;
            end
            for (int i = 0; i < 8; i++) begin
                mRegB[i]  <= '0;
                mBusyB[i] <= 1'b0;
            end
        end else begin
            if (wrA && wRegA != 5'd0) begin
                mRegA[wRegA]  <= wDataA;
                mBusyA[wRegA] <= 1'b0;
            end
            if (resA && resRegA != 5'd0) mBusyA[resRegA] <= 1'b1;
            if (wrB) begin
                mRegB[wRegB]  <= wDataB;
                mBusyB[wRegB] <= 1'b0;
            end
            if (resB) mBusyB[resRegB] <= 1'b1;
        end
    end

    function automatic logic [31:0] expDataA(input logic [4:0] r);
        if (!resetN || r == 5'd0) return 32'd0;
        if (wrA && wRegA == r) return wDataA;
        return mRegA[r];
    endfunction

    function automatic logic expBusyA(input logic [4:0] r);
        if (!resetN || r == 5'd0) return 1'b0;
        if (wrA && wRegA == r) return 1'b0;
        return mBusyA[r];
    endfunction

    function automatic logic [15:0] expDataB(input logic [2:0] r);
        if (!resetN) return 16'd0;
        return mRegB[r];
    endfunction

    function automatic logic expBusyB(input logic [2:0] r);
        if (!resetN) return 1'b0;
        return mBusyB[r];
    endfunction

    function automatic int countA();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(mBusyA[i]);
        return c;
    endfunction

    function automatic int countB();
        int c = 0;
        for (int i = 0; i < 8; i++) c += int'(mBusyB[i]);
        return c;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        #2;
        if (checkEn) begin
            checkOutput("A.data1", rData1A, expDataA(rd1A));
            checkOutput("A.data2", rData2A, expDataA(rd2A));
            checkOutput("A.busy1", 32'(busy1A), 32'(expBusyA(rd1A)));
            checkOutput("A.busy2", 32'(busy2A), 32'(expBusyA(rd2A)));
            checkOutput("A.count", 32'(cntA), 32'(countA()));
            checkOutput("B.data1", 32'(rData1B), 32'(expDataB(rd1B)));
            checkOutput("B.data2", 32'(rData2B), 32'(expDataB(rd2B)));
            checkOutput("B.busy1", 32'(busy1B), 32'(expBusyB(rd1B)));
            checkOutput("B.busy2", 32'(busy2B), 32'(expBusyB(rd2B)));
            checkOutput("B.count", 32'(cntB), 32'(countB()));
        end
    end

    task automatic applyStimulus(input logic wr, input logic [4:0] wReg, input logic [31:0] wData,
                                 input logic res, input logic [4:0] resReg,
                                 input logic [4:0] rd1, input logic [4:0] rd2);
        @(negedge clock);
        wrA = wr; wRegA = wReg; wDataA = wData;
        resA = res; resRegA = resReg; rd1A = rd1; rd2A = rd2;
        wrB = 1'b0; resB = 1'b0;
    endtask

    task automatic applyStimulusB(input logic wr, input logic [2:0] wReg, input logic [15:0] wData,
                                  input logic res, input logic [2:0] resReg,
                                  input logic [2:0] rd1, input logic [2:0] rd2);
        @(negedge clock);
        wrB = wr; wRegB = wReg; wDataB = wData;
        resB = res; resRegB = resReg; rd1B = rd1; rd2B = rd2;
        wrA = 1'b0; resA = 1'b0;
    endtask

    function automatic logic [4:0] randAddrA();
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 3));
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        wrA = 0; wRegA = 0; wDataA = 0; resA = 0; resRegA = 0; rd1A = 0; rd2A = 0;
        wrB = 0; wRegB = 0; wDataB = 0; resB = 0; resRegB = 0; rd1B = 0; rd2B = 0;
        #1 resetN = 1'b0;
        #2;
        checkOutput("reset.dataA", rData1A, 32'd0);
        checkOutput("reset.busyA", 32'(busy1A), 32'd0);
        checkOutput("reset.cntA", 32'(cntA), 32'd0);
        checkOutput("reset.cntB", 32'(cntB), 32'd0);
        checkEn = 1'b1;
        @(negedge clock);
        resetN = 1'b1;

        for (int a = 0; a < 32; a++) begin
            applyStimulus(0, 0, 0, 0, 0, 5'(a), 5'(31 - a));
            #2;
            checkOutput("readall.d1", rData1A, 32'd0);
            checkOutput("readall.d2", rData2A, 32'd0);
            checkOutput("readall.b1", 32'(busy1A), 32'd0);
        end

        applyStimulus(0, 0, 0, 1, 8, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 8, 0);
        #2;
        checkOutput("res8.busy1", 32'(busy1A), 32'd1);
        checkOutput("res8.cnt", 32'(cntA), 32'd1);
        applyStimulus(1, 8, 32'h12345678, 0, 0, 8, 8);
        #2;
        checkOutput("byp8.data1", rData1A, 32'h12345678);
        checkOutput("byp8.data2", rData2A, 32'h12345678);
        checkOutput("byp8.busy1", 32'(busy1A), 32'd0);
        checkOutput("byp8.cnt", 32'(cntA), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 8, 0);
        #2;
        checkOutput("wr8.data1", rData1A, 32'h12345678);
        checkOutput("wr8.cnt", 32'(cntA), 32'd0);

        applyStimulus(1, 9, 32'hA5A5A5A5, 1, 9, 9, 9);
        #2;
        checkOutput("rw9.bypBusy", 32'(busy1A), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 9, 9);
        #2;
        checkOutput("rw9.data1", rData1A, 32'hA5A5A5A5);
        checkOutput("rw9.busy1", 32'(busy1A), 32'd1);
        checkOutput("rw9.cnt", 32'(cntA), 32'd1);

        applyStimulus(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0);
        #2;
        checkOutput("zero.bypData", rData1A, 32'd0);
        checkOutput("zero.bypBusy", 32'(busy2A), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        #2;
        checkOutput("zero.data", rData2A, 32'd0);
        checkOutput("zero.cnt", 32'(cntA), 32'd1);

        applyStimulus(1, 5, 32'hDEADBEEF, 1, 5, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 5, 5);
        #2;
        checkOutput("r5.data", rData1A, 32'hDEADBEEF);
        checkOutput("r5.busy", 32'(busy1A), 32'd1);
        checkOutput("r5.cnt", 32'(cntA), 32'd2);
        #1 resetN = 1'b0;
        #1;
        checkOutput("async.data1", rData1A, 32'd0);
        checkOutput("async.data2", rData2A, 32'd0);
        checkOutput("async.busy", 32'(busy1A), 32'd0);
        checkOutput("async.cnt", 32'(cntA), 32'd0);
        @(negedge clock);
        resetN = 1'b1;

        applyStimulusB(1, 3, 16'h0042, 0, 0, 0, 0);
        applyStimulusB(1, 3, 16'h0007, 0, 0, 0, 3);
        #2;
        checkOutput("B.rbw.old", 32'(rData2B), 32'h0042);
        applyStimulusB(0, 0, 0, 0, 0, 0, 3);
        #2;
        checkOutput("B.rbw.new", 32'(rData2B), 32'h0007);
        applyStimulusB(1, 0, 16'hBEEF, 1, 1, 0, 0);
        applyStimulusB(0, 0, 0, 0, 0, 0, 1);
        #2;
        checkOutput("B.reg0", 32'(rData1B), 32'h0000BEEF);
        checkOutput("B.busy1", 32'(busy2B), 32'd1);
        checkOutput("B.cnt", 32'(cntB), 32'd1);

        for (int n = 0; n < 10000; n++) begin
            @(negedge clock);
            wrA = 1'($urandom_range(0, 1)); wRegA = randAddrA(); wDataA = $urandom;
            resA = 1'($urandom_range(0, 1)); resRegA = randAddrA();
            rd1A = randAddrA(); rd2A = randAddrA();
            wrB = 1'($urandom_range(0, 1)); wRegB = 3'($urandom); wDataB = 16'($urandom);
            resB = 1'($urandom_range(0, 1)); resRegB = 3'($urandom);
            rd1B = 3'($urandom); rd2B = 3'($urandom);
        end

        @(negedge clock);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
